// File: rtl/lut_cascade_if.sv
// lut_cascade_if
//   Bundles the logic-path and configuration-stream signals of one
//   lut_cascade instance. The clock and reset stay outside as plain ports.
//   master : the driving side (fabric / loader / testbench)
//   slave  : the lut_cascade block itself
// Signals:
//   addr          logic address (AW bits)
//   out           cascade output
//   config_en     shift one configuration word this cycle
//   config_in     configuration word in
//   config_out    configuration word out, feeds the next instance
//   config_commit request a shadow -> active copy
//   config_done   a full set of words has been shifted since reset/commit
//   commit_err    one-cycle pulse, commit requested while not done
interface lut_cascade_if #(
  parameter int AW           = 7,
  parameter int CONFIG_WIDTH = 8
);
  logic [AW-1:0]           addr;
  logic                    out;
  logic                    config_en;
  logic [CONFIG_WIDTH-1:0] config_in;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    config_commit;
  logic                    config_done;
  logic                    commit_err;

  modport master (
    output addr, config_en, config_in, config_commit,
    input  out, config_out, config_done, commit_err
  );

  modport slave (
    input  addr, config_en, config_in, config_commit,
    output out, config_out, config_done, commit_err
  );
endinterface

// File: rtl/lut_cascade.sv
// lut_cascade
//   A chain of STAGES K-input LUTs. Each stage's output is the MSB address
//   bit of the next stage; the last stage drives out. Truth tables are
//   loaded through a word-wide shift chain into a shadow store and copied
//   into the active tables atomically on a commit, so the logic function
//   never shows a half-loaded state.
// Ports:
//   config_clk  sole clock
//   config_rst  synchronous, active-high reset
//   bus         lut_cascade_if.slave (addr/out plus configuration stream)
// Build option:
//   LUT_CASCADE_OUTREG_EN  when defined, out is registered (one-cycle
//                          latency from addr or commit); otherwise out is
//                          purely combinational.
module lut_cascade #(
  parameter int STAGES       = 2,
  parameter int INPUTS       = 4,
  parameter int CONFIG_WIDTH = 8
) (
  input logic          config_clk,
  input logic          config_rst,
  lut_cascade_if.slave bus
);
  localparam int AW          = INPUTS + (STAGES - 1) * (INPUTS - 1);
  localparam int LUT_BITS    = 2 ** INPUTS;
  localparam int WPL         = LUT_BITS / CONFIG_WIDTH;
  localparam int TOTAL_WORDS = STAGES * WPL;
  localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);

  logic [CONFIG_WIDTH-1:0] shadow_reg [TOTAL_WORDS];
  logic [LUT_BITS-1:0]     active_reg [STAGES];
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  logic [CONFIG_WIDTH-1:0] config_out_reg;
  logic                    done_reg;
  logic                    commit_err_reg;
  logic                    commit_valid;

  // Shadow words regrouped into per-stage truth tables.
  logic [STAGES-1:0][LUT_BITS-1:0] stage_cfg;
  // Low INPUTS-1 address bits seen by each stage; the MSB comes from the
  // previous stage (or addr[AW-1] for stage 0).
  logic [STAGES-1:0][INPUTS-2:0]   low_addr;

  logic                    lut_carry;
  logic [INPUTS-1:0]       lut_idx;
  logic                    comb_out;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      for (gj = 0; gj < WPL; gj++) begin : g_word
        assign stage_cfg[gi][gj*CONFIG_WIDTH +: CONFIG_WIDTH] = shadow_reg[gi*WPL + gj];
      end
      assign low_addr[gi] = bus.addr[AW-2-gi*(INPUTS-1) -: INPUTS-1];
    end
  endgenerate

  assign commit_valid = bus.config_commit && done_reg;

  always_comb begin
    count_next = count_reg;
    if (commit_valid) begin
      // A shift in the commit cycle counts as the first word of the next load.
      count_next = bus.config_en ? CNT_W'(1) : '0;
    end else if (bus.config_en && (count_reg != CNT_W'(TOTAL_WORDS))) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      for (int i = 0; i < TOTAL_WORDS; i++) shadow_reg[i] <= '0;
      for (int s = 0; s < STAGES; s++) active_reg[s] <= '0;
      count_reg      <= '0;
      config_out_reg <= '0;
      done_reg       <= 1'b0;
      commit_err_reg <= 1'b0;
    end else begin
      // Commit copies the pre-shift shadow; a simultaneous shift lands after.
      if (commit_valid) begin
        for (int s = 0; s < STAGES; s++) active_reg[s] <= stage_cfg[s];
      end
      if (bus.config_en) begin
        shadow_reg[0] <= bus.config_in;
        for (int i = 1; i < TOTAL_WORDS; i++) shadow_reg[i] <= shadow_reg[i-1];
        config_out_reg <= shadow_reg[TOTAL_WORDS-1];
      end
      count_reg      <= count_next;
      done_reg       <= (count_next == CNT_W'(TOTAL_WORDS));
      commit_err_reg <= bus.config_commit && !done_reg;
    end
  end

  // Ripple through the stages: each stage's output becomes the MSB index
  // bit of the next stage's table.
  always_comb begin
    lut_carry = bus.addr[AW-1];
    lut_idx   = '0;
    for (int s = 0; s < STAGES; s++) begin
      lut_idx   = {lut_carry, low_addr[s]};
      lut_carry = active_reg[s][lut_idx];
    end
    comb_out = lut_carry;
  end

`ifdef LUT_CASCADE_OUTREG_EN
  logic out_reg;
  always_ff @(posedge config_clk) begin
    if (config_rst) out_reg <= 1'b0;
    else            out_reg <= comb_out;
  end
  assign bus.out = out_reg;
`else
  assign bus.out = comb_out;
`endif

  assign bus.config_out  = config_out_reg;
  assign bus.config_done = done_reg;
  assign bus.commit_err  = commit_err_reg;
endmodule

// File: tb/tb_lut_cascade.sv
module tb_lut_cascade;
  localparam int STAGES       = 2;
  localparam int INPUTS       = 4;
  localparam int CONFIG_WIDTH = 8;
  localparam int AW           = INPUTS + (STAGES - 1) * (INPUTS - 1);
  localparam int WPL          = (2 ** INPUTS) / CONFIG_WIDTH;
  localparam int TOTAL_WORDS  = STAGES * WPL;

  logic config_clk = 1'b0;
  logic config_rst = 1'b1;
  always #5 config_clk = ~config_clk;

  lut_cascade_if #(.AW(AW), .CONFIG_WIDTH(CONFIG_WIDTH)) bus ();

  lut_cascade #(.STAGES(STAGES), .INPUTS(INPUTS), .CONFIG_WIDTH(CONFIG_WIDTH)) dut (
    .config_clk (config_clk),
    .config_rst (config_rst),
    .bus        (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: shadow as a queue (index 0 = newest word), tables as
  // plain integers, counter as an int.
  int unsigned m_q[$];
  int unsigned m_table [STAGES];
  int unsigned m_cfg_out;
  int          m_count;
  bit          m_done;
  bit          m_err;

  typedef struct {
    logic [AW-1:0] addr;
    bit            exp_out;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < TOTAL_WORDS; i++) m_q.push_back(0);
    for (int s = 0; s < STAGES; s++) m_table[s] = 0;
    m_cfg_out = 0; m_count = 0; m_done = 0; m_err = 0;
  endtask

  function automatic int model_out(input int a);
    int idx, b;
    idx = a >> (AW - INPUTS);
    b   = (m_table[0] >> idx) & 1;
    for (int s = 1; s < STAGES; s++) begin
      idx = (b << (INPUTS - 1)) |
            ((a >> (AW - INPUTS - s * (INPUTS - 1))) & ((1 << (INPUTS - 1)) - 1));
      b   = (m_table[s] >> idx) & 1;
    end
    return b;
  endfunction

  task automatic step(input bit en, input int unsigned din, input bit cm);
    bit valid;
    bus.config_en     = en;
    bus.config_in     = din[CONFIG_WIDTH-1:0];
    bus.config_commit = cm;
    @(posedge config_clk);
    valid = cm && m_done;
    m_err = cm && !m_done;
    if (valid) begin
      for (int s = 0; s < STAGES; s++) begin
        m_table[s] = 0;
        for (int j = 0; j < WPL; j++) m_table[s] |= m_q[s*WPL + j] << (j * CONFIG_WIDTH);
      end
    end
    if (en) begin
      m_cfg_out = m_q.pop_back();
      m_q.push_front(din & ((1 << CONFIG_WIDTH) - 1));
    end
    if (valid) m_count = en ? 1 : 0;
    else if (en && m_count < TOTAL_WORDS) m_count++;
    m_done = (m_count == TOTAL_WORDS);
    #1;
    bus.config_en = 1'b0; bus.config_commit = 1'b0;
    $display("txn en=%0b in=%02h commit=%0b -> cfg_out=%02h done=%0b err=%0b",
             en, din & 8'hFF, cm, bus.config_out, bus.config_done, bus.commit_err);
  endtask

  task automatic do_reset();
    bus.config_en = 1'b0; bus.config_commit = 1'b0;
    config_rst = 1'b1;
    @(posedge config_clk);
    model_reset();
    #1;
    config_rst = 1'b0;
    $display("txn reset");
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".config_out"},  int'(bus.config_out),  int'(m_cfg_out));
    chk({tag, ".config_done"}, int'(bus.config_done), int'(m_done));
    chk({tag, ".commit_err"},  int'(bus.commit_err),  int'(m_err));
  endtask

  // Applies addr and compares out once it is valid (one idle cycle later
  // when the output is registered).
  task automatic check_out(input string tag, input int a, input int expected);
    bus.addr = a[AW-1:0];
`ifdef LUT_CASCADE_OUTREG_EN
    step(1'b0, 0, 1'b0);
`else
    #1;
`endif
    chk(tag, int'(bus.out), expected);
  endtask

  task automatic sweep_model(input string tag);
    for (int a = 0; a < (1 << AW); a++) check_out(tag, a, model_out(a));
  endtask

  task automatic load_test2();
    step(1, 'h69, 0); step(1, 'h96, 0); step(1, 'h80, 0); step(1, 'h00, 0);
  endtask

  initial begin
    bus.addr = '0; bus.config_en = 1'b0; bus.config_in = '0; bus.config_commit = 1'b0;
    vecs[0] = '{7'b1111000, 1'b1};
    vecs[1] = '{7'b1111001, 1'b0};
    vecs[2] = '{7'b0111000, 1'b0};
    vecs[3] = '{7'b0000000, 1'b0};
    vecs[4] = '{7'b1111111, 1'b0};
    vecs[5] = '{7'b1111011, 1'b1};
    vecs[6] = '{7'b0000001, 1'b1};

    // 1: reset state, out=0 everywhere
    do_reset();
    chk("rst.config_out", int'(bus.config_out), 0);
    chk("rst.config_done", int'(bus.config_done), 0);
    chk("rst.commit_err", int'(bus.commit_err), 0);
    for (int a = 0; a < (1 << AW); a++) check_out("rst.out", a, 0);

    // 2: XOR4 into stage 1, AND4 into stage 0, then commit
    load_test2();
    chk("t2.done_before", int'(bus.config_done), 1);
    step(0, 0, 1);
    chk("t2.done_after", int'(bus.config_done), 0);
    chk("t2.commit_err", int'(bus.commit_err), 0);
    for (int i = 0; i < 7; i++) check_out("t2.vec", int'(vecs[i].addr), int'(vecs[i].exp_out));

    // 4: reload without commit; old words stream out, tables unchanged
    step(1, 'h11, 0); chk("t4.cfg_out0", int'(bus.config_out), 'h69);
    step(1, 'h22, 0); chk("t4.cfg_out1", int'(bus.config_out), 'h96);
    step(1, 'h33, 0); chk("t4.cfg_out2", int'(bus.config_out), 'h80);
    step(1, 'h44, 0); chk("t4.cfg_out3", int'(bus.config_out), 'h00);
    chk("t4.done", int'(bus.config_done), 1);
    check_out("t4.out_held", 7'b1111000, 1);

    // 5: commit and shift together: active takes the old shadow, count=1
    step(1, 'hFF, 1);
    chk("t5.done", int'(bus.config_done), 0);
    chk("t5.commit_err", int'(bus.commit_err), 0);
    chk("t5.cfg_out", int'(bus.config_out), 'h11);
    sweep_model("t5.out");
    step(1, 'h01, 0); chk("t5.done_2w", int'(bus.config_done), 0);
    step(1, 'h02, 0); chk("t5.done_3w", int'(bus.config_done), 0);
    step(1, 'h03, 0); chk("t5.done_4w", int'(bus.config_done), 1);

    // 6: reset mid-load clears everything; a following commit is an error
    do_reset();
    load_test2(); step(0, 0, 1);
    step(1, 'hA5, 0); step(1, 'h5A, 0);
    do_reset();
    check_state("t6");
    chk("t6.out_cleared", int'(bus.out), 0);
    step(0, 0, 1);
    chk("t6.commit_err", int'(bus.commit_err), 1);

    // 3: incomplete load, commit refused
    do_reset();
    step(1, 'h69, 0); step(1, 'h96, 0); step(1, 'h80, 0);
    step(0, 0, 1);
    chk("t3.commit_err", int'(bus.commit_err), 1);
    step(0, 0, 0);
    chk("t3.err_one_cycle", int'(bus.commit_err), 0);
    for (int a = 0; a < (1 << AW); a++) check_out("t3.out", a, 0);
    step(1, 'h00, 0);
    chk("t3.done_4th", int'(bus.config_done), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r == 0) do_reset();
      else step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) == 0));
      check_state("rnd");
      begin
        int a;
        a = $urandom_range(0, (1 << AW) - 1);
        check_out("rnd.out", a, model_out(a));
      end
    end

`ifdef LUT_CASCADE_OUTREG_EN
    // Registered output lags addr by exactly one cycle
    do_reset();
    load_test2(); step(0, 0, 1);
    bus.addr = 7'b1111000; step(0, 0, 0);
    chk("lag.settled", int'(bus.out), 1);
    bus.addr = 7'b1111001; #1;
    chk("lag.before_edge", int'(bus.out), 1);
    step(0, 0, 0);
    chk("lag.after_edge", int'(bus.out), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
